// File: rtl/ooo_commit_buffer.sv
// ooo_commit_buffer: 8-entry in-order commit buffer. Four execution units can
// write back out of order, and entries retire strictly from the head. The
// buffer flushes on an exception or a branch mispredict, and stops for good
// (until reset) when it commits a halt entry.
module ooo_commit_buffer (
  input  logic        CLK,
  input  logic        RST,
  // allocation
  input  logic        alloc_req,
  input  logic [4:0]  alloc_rd,
  input  logic [31:0] alloc_pc,
  input  logic        alloc_halt,
  output logic        alloc_ack,
  output logic [2:0]  alloc_tag,
  // writeback ports
  input  logic        wb_valid_au,
  input  logic [2:0]  wb_tag_au,
  input  logic [31:0] wdata_au,
  input  logic        wb_valid_mu,
  input  logic [2:0]  wb_tag_mu,
  input  logic [31:0] wdata_mu,
  input  logic        wb_valid_du,
  input  logic [2:0]  wb_tag_du,
  input  logic [31:0] wdata_du,
  input  logic        wb_valid_ls,
  input  logic [2:0]  wb_tag_ls,
  input  logic [31:0] wdata_ls,
  input  logic        wb_mal_addr_ls,
  input  logic        wb_mispredict_au,
  input  logic [31:0] wb_target_au,
  // commit
  output logic        commit_valid,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] commit_pc,
  // control
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        exception,
  output logic        halt,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count
);

  localparam int DEPTH = 8;

  logic [2:0]  head_q, head_d, tail_q, tail_d;
  logic [3:0]  count_q, count_d;
  logic        halt_q, halt_d;

  logic        valid_q   [DEPTH];
  logic        valid_d   [DEPTH];
  logic        done_q    [DEPTH];
  logic        done_d    [DEPTH];
  logic [4:0]  rd_q      [DEPTH];
  logic [4:0]  rd_d      [DEPTH];
  logic [31:0] pc_q      [DEPTH];
  logic [31:0] pc_d      [DEPTH];
  logic [31:0] wdata_q   [DEPTH];
  logic [31:0] wdata_d   [DEPTH];
  logic        exc_q     [DEPTH];
  logic        exc_d     [DEPTH];
  logic        mispred_q [DEPTH];
  logic        mispred_d [DEPTH];
  logic [31:0] target_q  [DEPTH];
  logic [31:0] target_d  [DEPTH];
  logic        ehalt_q   [DEPTH];
  logic        ehalt_d   [DEPTH];

  assign full      = (count_q == 4'd8);
  assign empty     = (count_q == 4'd0);
  assign count     = count_q;
  assign alloc_tag = tail_q;
  assign halt      = halt_q;

  // Head-of-buffer commit decode, flush decision and allocation handshake
  always_comb begin
    commit_valid = valid_q[head_q] && done_q[head_q] && !halt_q;
    rf_wen       = 1'b0;
    rf_rd        = 5'd0;
    rf_wdata     = 32'd0;
    commit_pc    = 32'd0;
    flush        = 1'b0;
    exception    = 1'b0;
    flush_pc     = 32'd0;
    if (commit_valid) begin
      rf_rd     = rd_q[head_q];
      rf_wdata  = wdata_q[head_q];
      commit_pc = pc_q[head_q];
      rf_wen    = (rd_q[head_q] != 5'd0) && !exc_q[head_q];
      if (exc_q[head_q]) begin
        flush     = 1'b1;
        exception = 1'b1;
        flush_pc  = pc_q[head_q];
      end else if (mispred_q[head_q]) begin
        flush    = 1'b1;
        flush_pc = target_q[head_q];
      end
    end
    alloc_ack = alloc_req && !full && !flush && !halt_q;
  end

  // Next-state: flush wipes the buffer; otherwise writebacks, alloc and commit
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    halt_d  = halt_q;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i]   = valid_q[i];
      done_d[i]    = done_q[i];
      rd_d[i]      = rd_q[i];
      pc_d[i]      = pc_q[i];
      wdata_d[i]   = wdata_q[i];
      exc_d[i]     = exc_q[i];
      mispred_d[i] = mispred_q[i];
      target_d[i]  = target_q[i];
      ehalt_d[i]   = ehalt_q[i];
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
      head_d  = 3'd0;
      tail_d  = 3'd0;
      count_d = 4'd0;
    end else begin
      // only the highest-priority unit hitting an entry writes its fields
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          if (wb_valid_ls && wb_tag_ls == 3'(i)) begin
            done_d[i]  = 1'b1;
            wdata_d[i] = wdata_ls;
            exc_d[i]   = wb_mal_addr_ls;
          end else if (wb_valid_du && wb_tag_du == 3'(i)) begin
            done_d[i]  = 1'b1;
            wdata_d[i] = wdata_du;
          end else if (wb_valid_mu && wb_tag_mu == 3'(i)) begin
            done_d[i]  = 1'b1;
            wdata_d[i] = wdata_mu;
          end else if (wb_valid_au && wb_tag_au == 3'(i)) begin
            done_d[i]    = 1'b1;
            wdata_d[i]   = wdata_au;
            mispred_d[i] = wb_mispredict_au;
            target_d[i]  = wb_target_au;
          end
        end
      end
      if (alloc_ack) begin
        valid_d[tail_q]   = 1'b1;
        done_d[tail_q]    = 1'b0;
        exc_d[tail_q]     = 1'b0;
        mispred_d[tail_q] = 1'b0;
        rd_d[tail_q]      = alloc_rd;
        pc_d[tail_q]      = alloc_pc;
        ehalt_d[tail_q]   = alloc_halt;
        tail_d            = tail_q + 3'd1;
      end
      if (commit_valid) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 3'd1;
      end
      count_d = count_q + {3'b000, alloc_ack} - {3'b000, commit_valid};
    end

    if (commit_valid && ehalt_q[head_q]) halt_d = 1'b1;
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= 3'd0;
      tail_q  <= 3'd0;
      count_q <= 4'd0;
      halt_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        done_q[i]    <= 1'b0;
        rd_q[i]      <= 5'd0;
        pc_q[i]      <= 32'd0;
        wdata_q[i]   <= 32'd0;
        exc_q[i]     <= 1'b0;
        mispred_q[i] <= 1'b0;
        target_q[i]  <= 32'd0;
        ehalt_q[i]   <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      halt_q  <= halt_d;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= valid_d[i];
        done_q[i]    <= done_d[i];
        rd_q[i]      <= rd_d[i];
        pc_q[i]      <= pc_d[i];
        wdata_q[i]   <= wdata_d[i];
        exc_q[i]     <= exc_d[i];
        mispred_q[i] <= mispred_d[i];
        target_q[i]  <= target_d[i];
        ehalt_q[i]   <= ehalt_d[i];
      end
    end
  end

endmodule
